// File: rtl/div_unit.sv
// Iterative RV64M divide/remainder unit (DIV/DIVU/REM/REMU + W forms).
// Restoring division, one quotient bit per CALC cycle, valid/ready on both sides.
module div_unit #(
  parameter int XLEN = 64
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [1:0]      req_op_i,
  input  logic            req_word_i,
  input  logic [XLEN-1:0] src1_i,
  input  logic [XLEN-1:0] src2_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [XLEN-1:0] rslt_o,
  output logic            busy_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_CALC = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_e;

  state_e r_state, w_next;

  logic [1:0]      r_op;
  logic            r_word;
  logic [XLEN-1:0] r_a, r_b;
  logic [XLEN-1:0] r_rem, r_quo, r_div;
  logic [6:0]      r_cnt;
  logic            r_sq, r_sr;
  logic [XLEN-1:0] r_rslt;

  logic            w_accept;
  logic            w_signed;
  logic [XLEN-1:0] w_a_ext, w_b_ext, w_a_abs, w_b_abs, w_a_sx;
  logic            w_s1, w_s2;
  logic            w_b_zero, w_ovf, w_special;
  logic [XLEN-1:0] w_spec_rslt;
  logic [XLEN:0]   w_shift_rem;
  logic            w_ge;
  logic [XLEN-1:0] w_trial;
  logic [XLEN-1:0] w_q_fix, w_r_fix, w_sel, w_fix;

  assign w_accept = (r_state == S_IDLE) && req_valid_i && !flush_i;
  assign w_signed = ~r_op[0];

  // Operand preparation: W forms reinterpret the low 32 bits at 32-bit width.
  assign w_a_ext  = r_word ? {{32{w_signed & r_a[31]}}, r_a[31:0]} : r_a;
  assign w_b_ext  = r_word ? {{32{w_signed & r_b[31]}}, r_b[31:0]} : r_b;
  assign w_s1     = w_signed & w_a_ext[XLEN-1];
  assign w_s2     = w_signed & w_b_ext[XLEN-1];
  assign w_a_abs  = w_s1 ? (~w_a_ext + 1'b1) : w_a_ext;
  assign w_b_abs  = w_s2 ? (~w_b_ext + 1'b1) : w_b_ext;
  assign w_a_sx   = r_word ? {{32{r_a[31]}}, r_a[31:0]} : r_a;

  assign w_b_zero = r_word ? (r_b[31:0] == 32'd0) : (r_b == '0);
  assign w_ovf    = w_signed && (r_word
                    ? (r_a[31:0] == 32'h8000_0000 && r_b[31:0] == 32'hFFFF_FFFF)
                    : (r_a == {1'b1, {(XLEN-1){1'b0}}} && r_b == '1));
  assign w_special = w_b_zero || w_ovf;

  always_comb begin
    w_spec_rslt = '0;
    if (w_b_zero) w_spec_rslt = r_op[1] ? w_a_sx : '1;
    else          w_spec_rslt = r_op[1] ? '0 : w_a_sx;
  end

  // Trial subtraction; the shifted remainder can exceed 64 bits by one,
  // but when it is kept the difference is below the divisor and fits.
  assign w_shift_rem = {r_rem, r_quo[XLEN-1]};
  assign w_ge        = w_shift_rem >= {1'b0, r_div};
  assign w_trial     = w_shift_rem[XLEN-1:0] - r_div;

  assign w_q_fix = (w_signed && r_sq) ? (~r_quo + 1'b1) : r_quo;
  assign w_r_fix = (w_signed && r_sr) ? (~r_rem + 1'b1) : r_rem;
  assign w_sel   = r_op[1] ? w_r_fix : w_q_fix;
  assign w_fix   = r_word ? {{32{w_sel[31]}}, w_sel[31:0]} : w_sel;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = S_PREP;
      S_PREP: w_next = w_special ? S_DONE : S_CALC;
      S_CALC: if (r_cnt == 7'd1) w_next = S_FIX;
      S_FIX:  w_next = S_DONE;
      S_DONE: if (rsp_ready_i) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (flush_i) w_next = S_IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_op   <= '0;
      r_word <= 1'b0;
      r_a    <= '0;
      r_b    <= '0;
      r_rem  <= '0;
      r_quo  <= '0;
      r_div  <= '0;
      r_cnt  <= '0;
      r_sq   <= 1'b0;
      r_sr   <= 1'b0;
      r_rslt <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_op   <= req_op_i;
          r_word <= req_word_i;
          r_a    <= src1_i;
          r_b    <= src2_i;
        end
        S_PREP: begin
          if (w_special) begin
            r_rslt <= w_spec_rslt;
          end else begin
            r_rem <= '0;
            // W dividend goes to the top half so bits shift out MSB first.
            r_quo <= r_word ? {w_a_abs[31:0], 32'd0} : w_a_abs;
            r_div <= w_b_abs;
            r_cnt <= r_word ? 7'd32 : 7'd64;
            r_sq  <= w_s1 ^ w_s2;
            r_sr  <= w_s1;
          end
        end
        S_CALC: begin
          r_rem <= w_ge ? w_trial : w_shift_rem[XLEN-1:0];
          r_quo <= {r_quo[XLEN-2:0], w_ge};
          r_cnt <= r_cnt - 7'd1;
        end
        S_FIX: r_rslt <= w_fix;
        default: ;
      endcase
    end
  end

  assign req_ready_o = (r_state == S_IDLE);
  assign rsp_valid_o = (r_state == S_DONE);
  assign busy_o      = (r_state != S_IDLE);
  assign rslt_o      = r_rslt;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: results, latencies, special cases, backpressure,
// flush and mid-operation reset.
module tb_div_unit;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        flush_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [1:0]  req_op_i;
  logic        req_word_i;
  logic [63:0] src1_i, src2_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [63:0] rslt_o;
  logic        busy_o;

  int checks   = 0;
  int failures = 0;

  localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

  div_unit #(.XLEN(64)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_op_i(req_op_i), .req_word_i(req_word_i),
    .src1_i(src1_i), .src2_i(src2_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rslt_o(rslt_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  // Issue one request; lat = edge count after the accept edge at which rsp_valid_o is first seen.
  task automatic run(input logic [1:0] op, input logic word, input logic [63:0] a,
                     input logic [63:0] b, output logic [63:0] res, output int lat);
    @(negedge clk_i);
    req_valid_i = 1'b1; req_op_i = op; req_word_i = word; src1_i = a; src2_i = b;
    @(posedge clk_i);
    @(negedge clk_i);
    req_valid_i = 1'b0;
    lat = 0;
    while (!rsp_valid_o && lat < 200) begin
      @(negedge clk_i);
      lat++;
    end
    res = rslt_o;
  endtask

  task automatic handshake();
    @(negedge clk_i);
    rsp_ready_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    rsp_ready_i = 1'b0;
  endtask

  task automatic op_check(input string tag, input logic [1:0] op, input logic word,
                          input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] exp, input int exp_lat);
    logic [63:0] res;
    int lat;
    run(op, word, a, b, res, lat);
    check({tag, "_rslt"}, res, exp);
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    handshake();
  endtask

  initial begin
    logic [63:0] res, held;
    int lat;
    logic stable, seen;

    rst_ni = 1'b0; flush_i = 1'b0; req_valid_i = 1'b0; req_op_i = '0; req_word_i = 1'b0;
    src1_i = '0; src2_i = '0; rsp_ready_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check("rst_req_ready", 64'(req_ready_o), 64'd1);
    check("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
    check("rst_rslt", rslt_o, 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    rst_ni = 1'b1;

    // Signed 64-bit, with backpressure on the first result
    run(OP_DIV, 1'b0, -64'sd7, 64'd2, res, lat);
    check("div_m7_2_rslt", res, 64'hFFFF_FFFF_FFFF_FFFD);
    check("div_m7_2_lat", 64'(lat), 64'd66);
    held = rslt_o;
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      if (!rsp_valid_o || rslt_o !== held || req_ready_o !== 1'b0) stable = 1'b0;
    end
    check("hold_stable", 64'(stable), 64'd1);
    check("hold_req_ready", 64'(req_ready_o), 64'd0);
    // Request offered during the response handshake cycle must not be taken
    @(negedge clk_i);
    rsp_ready_i = 1'b1; req_valid_i = 1'b1; req_op_i = OP_DIVU; src1_i = 64'd9; src2_i = 64'd3;
    @(posedge clk_i);
    @(negedge clk_i);
    rsp_ready_i = 1'b0; req_valid_i = 1'b0;
    check("hs_req_ready", 64'(req_ready_o), 64'd1);
    check("hs_rsp_valid", 64'(rsp_valid_o), 64'd0);
    check("hs_busy", 64'(busy_o), 64'd0);

    op_check("rem_m7_2", OP_REM, 1'b0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 66);
    op_check("divu_0", OP_DIVU, 1'b0, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    op_check("remu_0", OP_REMU, 1'b0, 64'h1234, 64'd0, 64'h1234, 1);
    op_check("div_ovf", OP_DIV, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
             64'h8000_0000_0000_0000, 1);
    op_check("rem_ovf", OP_REM, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1);
    op_check("divw_ovf", OP_DIV, 1'b1, 64'h1_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
             64'hFFFF_FFFF_8000_0000, 1);
    op_check("divuw_1", OP_DIVU, 1'b1, 64'hFFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 34);
    op_check("remuw_2", OP_REMU, 1'b1, 64'hABCD_0000_FFFF_FFFF, 64'h1234_0000_0000_0002, 64'd1, 34);
    op_check("divw_m7_2", OP_DIV, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'h5555_0000_0000_0002,
             64'hFFFF_FFFF_FFFF_FFFD, 34);
    op_check("remw_m7_2", OP_REM, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 34);
    op_check("remu_100_7", OP_REMU, 1'b0, 64'd100, 64'd7, 64'd2, 66);
    op_check("div_100_m7", OP_DIV, 1'b0, 64'd100, -64'sd7, -64'sd14, 66);

    // Flush together with a request in IDLE: request dropped
    @(negedge clk_i);
    flush_i = 1'b1; req_valid_i = 1'b1; req_op_i = OP_DIVU; src1_i = 64'd5; src2_i = 64'd1;
    @(posedge clk_i);
    @(negedge clk_i);
    flush_i = 1'b0; req_valid_i = 1'b0;
    check("idle_flush_busy", 64'(busy_o), 64'd0);

    // Flush at CALC cycle 20
    @(negedge clk_i);
    req_valid_i = 1'b1; req_op_i = OP_DIVU; req_word_i = 1'b0; src1_i = 64'd1000; src2_i = 64'd3;
    @(posedge clk_i);
    @(negedge clk_i);
    req_valid_i = 1'b0;
    repeat (20) @(negedge clk_i);
    check("pre_flush_busy", 64'(busy_o), 64'd1);
    flush_i = 1'b1;
    @(negedge clk_i);
    flush_i = 1'b0;
    check("flush_busy", 64'(busy_o), 64'd0);
    check("flush_req_ready", 64'(req_ready_o), 64'd1);
    seen = 1'b0;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk_i);
      if (rsp_valid_o) seen = 1'b1;
    end
    check("flush_no_rsp", 64'(seen), 64'd0);

    // Reset pulse mid-CALC
    @(negedge clk_i);
    req_valid_i = 1'b1; req_op_i = OP_DIV; src1_i = 64'd77; src2_i = 64'd5;
    @(posedge clk_i);
    @(negedge clk_i);
    req_valid_i = 1'b0;
    repeat (30) @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    check("midrst_busy", 64'(busy_o), 64'd0);
    check("midrst_rsp_valid", 64'(rsp_valid_o), 64'd0);
    check("midrst_rslt", rslt_o, 64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk_i);
      if (rsp_valid_o) seen = 1'b1;
    end
    check("midrst_no_rsp", 64'(seen), 64'd0);

    op_check("divu_100_7", OP_DIVU, 1'b0, 64'd100, 64'd7, 64'd14, 66);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
